// File: rtl/mole_pkg.sv
// mole_pkg: shared phase encoding, LFSR and window constants for the mole game.
package mole_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_WAIT = 2'd1,
        PH_UP   = 2'd2
    } phase_e;

    localparam int LFSR_W = 8;
    // Taps 8,6,5,4 (1-based) map to state bits 7,5,4,3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;
    localparam int WIN_W = 5;

endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 8-bit Fibonacci LFSR, synchronous reset to SEED.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q, state_d;

    always_comb state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};

    always_ff @(posedge clk) begin
        if (reset) state_q <= SEED;
        else       state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: random gap, timed mole-up window, hit/miss judging and
// difficulty ramp that shortens the window after every hit.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int                GAP_MIN    = 20,
    parameter int                GAP_RAND_W = 4,
    parameter int                WIN_START  = 16,
    parameter int                WIN_MIN    = 4,
    parameter int                WIN_STEP   = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             button,
    output logic             mole,
    output logic             hit,
    output logic             miss,
    output logic [WIN_W-1:0] window,
    output logic [1:0]       phase
);

    localparam int GAP_MAX = GAP_MIN - 1 + (1 << GAP_RAND_W) - 1;
    localparam int GAP_W   = GAP_MAX > 0 ? $clog2(GAP_MAX + 1) : 1;
    localparam logic [LFSR_W-1:0] RMASK = LFSR_W'((1 << GAP_RAND_W) - 1);

    logic [LFSR_W-1:0] lfsr;
    phase_e            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d, gap_load;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]  window_q, window_d, win_dec;
    logic              mole_q, mole_d, hit_q, hit_d, miss_q, miss_d;
    logic              button_q, press;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .state(lfsr)
    );

    assign press    = button & ~button_q;
    assign gap_load = GAP_W'(GAP_MIN - 1) + GAP_W'(lfsr & RMASK);
    // Saturating decrement: never drops below WIN_MIN, never wraps.
    assign win_dec  = (window_q >= WIN_W'(WIN_MIN + WIN_STEP)) ?
                      window_q - WIN_W'(WIN_STEP) : WIN_W'(WIN_MIN);

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        win_cnt_d = win_cnt_q;
        window_d  = window_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        if (!enable) begin
            state_d  = PH_IDLE;
            window_d = WIN_W'(WIN_START);
        end else begin
            case (state_q)
                PH_IDLE: begin
                    state_d = PH_WAIT;
                    gap_d   = gap_load;
                end
                PH_WAIT: begin
                    if (gap_q == '0) begin
                        state_d   = PH_UP;
                        win_cnt_d = window_q - WIN_W'(1);
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                PH_UP: begin
                    // A press wins over expiry on the last window cycle.
                    if (press) begin
                        state_d  = PH_WAIT;
                        hit_d    = 1'b1;
                        gap_d    = gap_load;
                        window_d = win_dec;
                    end else if (win_cnt_q == '0) begin
                        state_d = PH_WAIT;
                        miss_d  = 1'b1;
                        gap_d   = gap_load;
                    end else begin
                        win_cnt_d = win_cnt_q - WIN_W'(1);
                    end
                end
                default: state_d = PH_IDLE;
            endcase
        end
        mole_d = (state_d == PH_UP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PH_IDLE;
            gap_q     <= '0;
            win_cnt_q <= '0;
            window_q  <= WIN_W'(WIN_START);
            mole_q    <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            button_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            win_cnt_q <= win_cnt_d;
            window_q  <= window_d;
            mole_q    <= mole_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            button_q  <= button;
        end
    end

    assign mole   = mole_q;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign window = window_q;
    assign phase  = state_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: two DUT configurations checked every cycle against an
// appearance-level reference model, plus directed timing/ramp scenarios.
module tb_mole_scheduler;

    logic            clk;
    logic [1:0]      rst, en, btn;
    logic [1:0]      mole, hit, miss;
    logic [1:0][4:0] win;
    logic [1:0][1:0] ph;

    int vectors = 0;
    int miscompares = 0;

    mole_scheduler #(.GAP_MIN(4), .GAP_RAND_W(0), .WIN_START(6)) dut_a (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .button(btn[0]),
        .mole(mole[0]), .hit(hit[0]), .miss(miss[0]), .window(win[0]), .phase(ph[0])
    );

    mole_scheduler dut_b (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .button(btn[1]),
        .mole(mole[1]), .hit(hit[1]), .miss(miss[1]), .window(win[1]), .phase(ph[1])
    );

    always #5 clk = ~clk;

    int P_GMIN[2] = '{4, 20};
    int P_RW[2]   = '{0, 4};
    int P_WS[2]   = '{6, 16};

    // Model: phase, cycles left in the current phase, window, event flags.
    int         m_ph[2], m_left[2], m_win[2], m_hit[2], m_miss[2], m_prev[2];
    logic [7:0] m_lfsr[2];

    function automatic logic [7:0] lfsr_next(logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(int k);
        bit press;
        int gap;
        if (rst[k]) begin
            m_ph[k] = 0; m_left[k] = 0; m_win[k] = P_WS[k];
            m_hit[k] = 0; m_miss[k] = 0; m_prev[k] = 0; m_lfsr[k] = 8'hA5;
            return;
        end
        press = btn[k] && !m_prev[k];
        gap = P_GMIN[k] + (int'(m_lfsr[k]) % (1 << P_RW[k]));
        m_hit[k] = 0;
        m_miss[k] = 0;
        if (!en[k]) begin
            m_ph[k] = 0; m_win[k] = P_WS[k];
        end else if (m_ph[k] == 0) begin
            m_ph[k] = 1; m_left[k] = gap;
        end else if (m_ph[k] == 1) begin
            if (m_left[k] == 1) begin m_ph[k] = 2; m_left[k] = m_win[k]; end
            else m_left[k]--;
        end else if (press) begin
            m_hit[k] = 1; m_ph[k] = 1; m_left[k] = gap;
            m_win[k] = (m_win[k] - 2 < 4) ? 4 : m_win[k] - 2;
        end else if (m_left[k] == 1) begin
            m_miss[k] = 1; m_ph[k] = 1; m_left[k] = gap;
        end else m_left[k]--;
        m_prev[k] = btn[k];
        m_lfsr[k] = lfsr_next(m_lfsr[k]);
    endtask

    task automatic tick();
        string p;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            p = k ? "b_" : "a_";
            chk({p, "phase"}, ph[k], m_ph[k]);
            chk({p, "mole"}, mole[k], m_ph[k] == 2);
            chk({p, "hit"}, hit[k], m_hit[k]);
            chk({p, "miss"}, miss[k], m_miss[k]);
            chk({p, "window"}, win[k], m_win[k]);
            chk({p, "exclusive"}, hit[k] & miss[k], 0);
        end
        chk("a_lfsr_nonzero", dut_a.lfsr != 8'h00, 1);
        chk("b_lfsr_nonzero", dut_b.lfsr != 8'h00, 1);
    endtask

    task automatic wait_mole(int k, output int n);
        n = 0;
        while (!mole[k] && n < 200) begin tick(); n++; end
        chk("wait_mole_bound", mole[k], 1);
    endtask

    task automatic up_len(int k, output int n);
        n = 0;
        while (mole[k] && n < 200) begin tick(); n++; end
    endtask

    initial begin
        int n, gaps, cnt, cyc;
        bit seen, prev_m;
        clk = 0; rst = 2'b11; en = 2'b00; btn = 2'b00;
        tick(); tick();
        chk("a_rst_phase", ph[0], 0);
        chk("a_rst_mole", mole[0], 0);
        chk("a_rst_window", win[0], 6);
        chk("b_rst_window", win[1], 16);
        rst = 2'b00;
        // Fixed gap: 4 WAIT cycles, 6 UP cycles, then a miss.
        en[0] = 1;
        wait_mole(0, n);
        chk("a_wait_len", n - 1, 4);
        up_len(0, n);
        chk("a_up_len", n, 6);
        chk("a_miss_pulse", miss[0], 1);
        chk("a_window_after_miss", win[0], 6);
        // Press on 3rd UP cycle.
        wait_mole(0, n);
        tick(); tick();
        btn[0] = 1; tick();
        chk("a_hit3", hit[0], 1);
        chk("a_hit3_mole", mole[0], 0);
        chk("a_hit3_window", win[0], 4);
        btn[0] = 0;
        wait_mole(0, n);
        up_len(0, n);
        chk("a_up_len4", n, 4);
        // Press on the final UP cycle counts as a hit.
        wait_mole(0, n);
        tick(); tick(); tick();
        btn[0] = 1; tick();
        chk("a_last_hit", hit[0], 1);
        chk("a_last_nomiss", miss[0], 0);
        chk("a_floor_window", win[0], 4);
        // Held button from WAIT into UP: no press, expiry gives a miss.
        wait_mole(0, n);
        up_len(0, n);
        chk("a_held_up_len", n, 4);
        chk("a_held_miss", miss[0], 1);
        chk("a_held_nohit", hit[0], 0);
        btn[0] = 0;
        // Enable drop during UP with a simultaneous press.
        wait_mole(0, n);
        tick();
        en[0] = 0; btn[0] = 1; tick();
        chk("a_drop_phase", ph[0], 0);
        chk("a_drop_hit", hit[0], 0);
        chk("a_drop_window", win[0], 6);
        btn[0] = 0; en[0] = 1; tick();
        chk("a_reenable_phase", ph[0], 1);
        // Difficulty ramp on default params.
        en[1] = 1;
        for (int i = 0; i < 12; i++) begin
            wait_mole(1, n);
            btn[1] = 1; tick();
            chk("b_ramp_hit", hit[1], 1);
            chk("b_ramp_window", win[1], (16 - 2 * (i + 1) < 4) ? 4 : 16 - 2 * (i + 1));
            btn[1] = 0; tick();
        end
        wait_mole(1, n);
        en[1] = 0; btn[1] = 1; tick();
        chk("b_drop_phase", ph[1], 0);
        chk("b_drop_mole", mole[1], 0);
        chk("b_drop_miss", miss[1], 0);
        chk("b_drop_window", win[1], 16);
        btn[1] = 0; en[1] = 1; tick();
        chk("b_reenable_phase", ph[1], 1);
        // Reset in the middle of an appearance.
        wait_mole(1, n);
        rst[1] = 1; tick();
        chk("b_rst_mid_mole", mole[1], 0);
        chk("b_rst_mid_phase", ph[1], 0);
        chk("b_rst_mid_window", win[1], 16);
        rst[1] = 0;
        // Random traffic on both instances.
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(0, 499) == 0);
                en[k]  = ($urandom_range(0, 49) != 0);
                btn[k] = ($urandom_range(0, 5) == 0);
            end
            tick();
        end
        // 1000 gaps with enable held: every gap must lie in 20..35.
        rst = 2'b00; en = 2'b11;
        gaps = 0; cnt = 0; cyc = 0; seen = 0; prev_m = mole[1];
        while (gaps < 1000 && cyc < 80000) begin
            btn[0] = ($urandom_range(0, 3) == 0);
            btn[1] = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
            if (!mole[1]) begin
                if (prev_m) begin seen = 1; cnt = 0; end
                cnt++;
            end else if (!prev_m && seen) begin
                chk("b_gap_range", cnt >= 20 && cnt <= 35, 1);
                gaps++;
            end
            prev_m = mole[1];
        end
        chk("b_gap_count", gaps, 1000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
